// File: rtl/t01_pkg.sv
// Shared types for the RV32I instruction encoder slice.
// Holds the format enum, the canonical NOP and the FIFO entry layout.
package t01_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Entries carry a wide address; the top narrows it to ADDR_W.
  localparam int ADDR_MAX = 64;

  typedef struct packed {
    logic [31:0]         instr;
    logic [ADDR_MAX-1:0] addr;
    logic                err;
  } entry_t;

endpackage

// File: rtl/t01_instruction_encoder_pack.sv
// Combinational packer: decoded fields + fmt -> {instr, err}.
// Ports: fmt/opcode/rd/rs1/rs2/funct3/funct7/imm in; instr/err out.
module t01_instr_pack
  import t01_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  // Sign-extension checks: the dropped high bits must all match.
  logic fits12;
  logic fits13;
  logic fits21;

  assign fits12 = imm[31:11] == {21{imm[31]}};
  assign fits13 = imm[31:12] == {20{imm[31]}};
  assign fits21 = imm[31:20] == {12{imm[31]}};

  always_comb begin
    instr = NOP;
    err   = 1'b1;
    case (fmt)
      FMT_R: begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
        err   = 1'b0;
      end
      FMT_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = !fits12;
      end
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3,
                 imm[4:0], opcode};
        err   = !fits12;
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                 imm[4:1], imm[11], opcode};
        err   = !fits13 || imm[0];
      end
      FMT_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = imm[11:0] != 12'h000;
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11],
                 imm[19:12], rd, opcode};
        err   = !fits21 || imm[0];
      end
      default: begin
        instr = NOP;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/t01_instruction_encoder.sv
// RV32I word encoder: packs fields, tags an address, 2-deep out FIFO.
// Ports: clk/rst/flush, in_* valid/ready fields, out_* handshake, err_count.
module t01_instruction_encoder
  import t01_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  entry_t            mem [2];
  entry_t            head;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        err_q;
  logic [31:0]       pk_instr;
  logic              pk_err;
  logic              full;
  logic              push;
  logic              pop;

  t01_instr_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .instr  (pk_instr),
    .err    (pk_err)
  );

  assign full      = count == 2'd2;
  assign in_ready  = !full && !flush;
  assign out_valid = count != 2'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  assign head      = mem[rd_ptr];
  assign out_instr = head.instr;
  assign out_addr  = ADDR_W'(head.addr);
  assign out_err   = head.err;
  assign err_count = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Entry 0 doubles as the idle head, so it holds reset values.
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '{instr: '0,
                    addr:  ADDR_MAX'(BASE_ADDR),
                    err:   1'b0};
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      addr_q <= BASE_ADDR;
      err_q  <= 8'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      addr_q <= BASE_ADDR;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{instr: pk_instr,
                         addr:  ADDR_MAX'(addr_q),
                         err:   pk_err};
        wr_ptr <= ~wr_ptr;
        addr_q <= addr_q + ADDR_W'(4);
        if (pk_err && err_q != 8'hFF) begin
          err_q <= err_q + 8'd1;
        end
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
